// File: rtl/inst_loader_if.sv
// Byte-stream input, instruction-memory write port and session status of inst_loader.
// The loader connects through the slave modport; the driving side uses master.
interface inst_loader_if;
   logic        start;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] word_cnt;

   modport master (
      output start, rx_valid, rx_data,
      input  rx_ready, mem_we, mem_addr, mem_data, busy, done, error, word_cnt
   );

   modport slave (
      input  start, rx_valid, rx_data,
      output rx_ready, mem_we, mem_addr, mem_data, busy, done, error, word_cnt
   );
endinterface

// File: rtl/inst_loader.sv
// Loads a length-prefixed big-endian word stream into instruction memory.
// Optional trailing checksum check is compiled in with INST_LOADER_CHECKSUM_EN.
module inst_loader #(
   parameter int          MEM_AW    = 17,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input logic         clk,
   input logic         rst,
   inst_loader_if.slave lif
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CHK  = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_e;

   localparam logic [32:0] MAX_WORDS = 33'd1 << MEM_AW;

   function automatic logic [31:0] be_word(input logic [23:0] hi, input logic [7:0] lo);
      return {hi, lo};
   endfunction

   state_e      state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0] shift_q, shift_d;
   logic [31:0] len_q, len_d;
   logic [31:0] word_cnt_q, word_cnt_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_data_q, mem_data_d;

   logic        rx_ready_s;
   logic        accept_s;
   logic        last_byte_s;
   logic        start_s;
   logic [31:0] word_s;

   assign rx_ready_s  = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);
   assign accept_s    = lif.rx_valid && rx_ready_s;
   assign last_byte_s = accept_s && (byte_cnt_q == 2'd3);
   assign start_s     = lif.start && !rx_ready_s;
   assign word_s      = be_word(shift_q, lif.rx_data);

`ifdef INST_LOADER_CHECKSUM_EN
   logic [31:0] sum_q, sum_d;

   // Running sum of every data word, cleared at session start.
   always_comb begin
      sum_d = sum_q;
      if (start_s) begin
         sum_d = 32'd0;
      end else if ((state_q == ST_DATA) && last_byte_s) begin
         sum_d = sum_q + word_s;
      end else begin
         sum_d = sum_q;
      end
   end

   // Checksum accumulator register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q <= 32'd0;
      end else begin
         sum_q <= sum_d;
      end
   end
`endif

   // Next-state, byte assembly and memory-write decode.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;

      if (accept_s) begin
         byte_cnt_d = byte_cnt_q + 2'd1;
         shift_d    = word_s[23:0];
      end else begin
         byte_cnt_d = byte_cnt_q;
         shift_d    = shift_q;
      end

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start_s) begin
               state_d    = ST_LEN;
               byte_cnt_d = 2'd0;
               shift_d    = 24'd0;
               len_d      = 32'd0;
               word_cnt_d = 32'd0;
            end else begin
               state_d = state_q;
            end
         end
         ST_LEN: begin
            if (last_byte_s) begin
               len_d = word_s;
               if (word_s == 32'd0) begin
                  state_d = ST_DONE;
               end else if ({1'b0, word_s} > MAX_WORDS) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_LEN;
            end
         end
         ST_DATA: begin
            if (last_byte_s) begin
               // Write lands one cycle after the last byte; word_cnt doubles as the word index.
               mem_we_d   = 1'b1;
               mem_addr_d = BASE_ADDR + {word_cnt_q[29:0], 2'b00};
               mem_data_d = word_s;
               word_cnt_d = word_cnt_q + 32'd1;
               if ((word_cnt_q + 32'd1) == len_q) begin
`ifdef INST_LOADER_CHECKSUM_EN
                  state_d = ST_CHK;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
`ifdef INST_LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (last_byte_s) begin
               state_d = (word_s == sum_q) ? ST_DONE : ST_ERR;
            end else begin
               state_d = ST_CHK;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         byte_cnt_q <= 2'd0;
         shift_q    <= 24'd0;
         len_q      <= 32'd0;
         word_cnt_q <= 32'd0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= 32'd0;
         mem_data_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
      end
   end

   assign lif.rx_ready = rx_ready_s;
   assign lif.busy     = rx_ready_s;
   assign lif.done     = (state_q == ST_DONE);
   assign lif.error    = (state_q == ST_ERR);
   assign lif.mem_we   = mem_we_q;
   assign lif.mem_addr = mem_addr_q;
   assign lif.mem_data = mem_data_q;
   assign lif.word_cnt = word_cnt_q;

endmodule

// File: tb/tb_inst_loader.sv
// Table-driven bench for inst_loader: dut0 uses default parameters, dut1 uses
// MEM_AW=4 and BASE_ADDR=0x100; both share the byte stream but have separate starts.
module tb_inst_loader;

`ifdef INST_LOADER_CHECKSUM_EN
   localparam bit CHK_ON = 1'b1;
`else
   localparam bit CHK_ON = 1'b0;
`endif

   typedef struct {
      bit               d1;
      logic [31:0]      n;
      logic [2:0][31:0] w;
      logic [31:0]      delta;
      bit               gaps;
      bit               smid;
      bit               exp_done;
      bit               exp_err;
      logic [31:0]      exp_cnt;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       start0;
   logic       start1;
   logic       rx_valid;
   logic [7:0] rx_data;

   int n_checks;
   int n_fail;

   logic [31:0] wa0[$];
   logic [31:0] wd0[$];
   logic [31:0] wa1[$];
   logic [31:0] wd1[$];

   vec_t vecs[8];

   inst_loader_if if0 ();
   inst_loader_if if1 ();

   assign if0.start    = start0;
   assign if0.rx_valid = rx_valid;
   assign if0.rx_data  = rx_data;
   assign if1.start    = start1;
   assign if1.rx_valid = rx_valid;
   assign if1.rx_data  = rx_data;

   inst_loader dut0 (
      .clk (clk),
      .rst (rst),
      .lif (if0)
   );

   inst_loader #(.MEM_AW(4), .BASE_ADDR(32'h0000_0100)) dut1 (
      .clk (clk),
      .rst (rst),
      .lif (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write capture, sampled away from the active edge.
   always @(negedge clk) begin
      if (if0.mem_we === 1'b1) begin
         wa0.push_back(if0.mem_addr);
         wd0.push_back(if0.mem_data);
      end
      if (if1.mem_we === 1'b1) begin
         wa1.push_back(if1.mem_addr);
         wd1.push_back(if1.mem_data);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input bit d1, input logic [7:0] b, input int gap);
      int t;
      for (int g = 0; g < gap; g++) begin
         rx_valid = 1'b0;
         @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = b;
      t = 0;
      while (((d1 ? if1.rx_ready : if0.rx_ready) !== 1'b1) && (t < 16)) begin
         @(negedge clk);
         t++;
      end
      if (t >= 16) begin
         n_fail++;
         $display("FAIL rx_ready_wait: ready stayed low for byte %h", b);
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input bit d1, input logic [31:0] w, input bit gaps);
      for (int i = 3; i >= 0; i--) begin
         send_byte(d1, w[8*i +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
      end
   endtask

   task automatic pulse_start(input bit d1);
      if (d1) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   function automatic logic [31:0] wgen(input vec_t v, input int k);
      return (k < 3) ? v.w[k] : (32'hA500_0000 + 32'(k));
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      logic [31:0] sum;
      logic [31:0] base;
      logic [31:0] wv;
      int          nw;
      int          t;
      int          nbytes;
      string       tag;
      base   = v.d1 ? 32'h0000_0100 : 32'h0000_0000;
      sum    = 32'd0;
      nw     = int'(v.exp_cnt);
      nbytes = 0;
      wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
      pulse_start(v.d1);
      send_word(v.d1, v.n, v.gaps);
      for (int k = 0; k < nw; k++) begin
         wv  = wgen(v, k);
         sum = sum + wv;
         for (int i = 3; i >= 0; i--) begin
            nbytes++;
            if (v.smid && (nbytes == 5)) begin
               if (v.d1) start1 = 1'b1; else start0 = 1'b1;
            end
            send_byte(v.d1, wv[8*i +: 8], v.gaps ? int'($urandom_range(0, 3)) : 0);
            start0 = 1'b0;
            start1 = 1'b0;
         end
      end
      if (CHK_ON && (nw > 0)) begin
         send_word(v.d1, sum + v.delta, v.gaps);
      end
      t = 0;
      while (((v.d1 ? (if1.done | if1.error) : (if0.done | if0.error)) !== 1'b1) && (t < 20)) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      tag = $sformatf("v%0d", idx);
      chk({tag, "_done"},     v.d1 ? if1.done : if0.done,         32'(v.exp_done));
      chk({tag, "_error"},    v.d1 ? if1.error : if0.error,       32'(v.exp_err));
      chk({tag, "_busy"},     v.d1 ? if1.busy : if0.busy,         32'd0);
      chk({tag, "_rx_ready"}, v.d1 ? if1.rx_ready : if0.rx_ready, 32'd0);
      chk({tag, "_mem_we"},   v.d1 ? if1.mem_we : if0.mem_we,     32'd0);
      chk({tag, "_word_cnt"}, v.d1 ? if1.word_cnt : if0.word_cnt, v.exp_cnt);
      chk({tag, "_nwrites"},  v.d1 ? wa1.size() : wa0.size(),     v.exp_cnt);
      chk({tag, "_other_nwrites"}, v.d1 ? wa0.size() : wa1.size(), 32'd0);
      for (int k = 0; k < nw; k++) begin
         if (k < (v.d1 ? wa1.size() : wa0.size())) begin
            chk($sformatf("%s_addr%0d", tag, k), v.d1 ? wa1[k] : wa0[k], base + 32'(4 * k));
            chk($sformatf("%s_data%0d", tag, k), v.d1 ? wd1[k] : wd0[k], wgen(v, k));
         end
      end
      if (nw > 0) begin
         chk({tag, "_addr_hold"}, v.d1 ? if1.mem_addr : if0.mem_addr, base + 32'(4 * (nw - 1)));
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      start0   = 1'b0;
      start1   = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;

      //          d1    n       w[2],w[1],w[0]                            delta gaps smid done     err     cnt
      vecs[0] = '{1'b0, 32'd2,  {32'h0, 32'h3402_1234, 32'h2401_0005}, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2};
      vecs[1] = '{1'b0, 32'd0,  {32'h0, 32'h0, 32'h0},                 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0};
      vecs[2] = '{1'b1, 32'h11, {32'h0, 32'h0, 32'h0},                 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0};
      vecs[3] = '{1'b0, 32'd3,  {32'h1234_5678, 32'hFFFF_FFFF, 32'h1}, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd3};
      vecs[4] = '{1'b1, 32'd1,  {32'h0, 32'h0, 32'hDEAD_BEEF},         32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1};
      vecs[5] = '{1'b0, 32'd1,  {32'h0, 32'h0, 32'h1122_3344},         32'd1, 1'b0, 1'b0, !CHK_ON, CHK_ON, 32'd1};
      vecs[6] = '{1'b0, 32'd3,  {32'h8000_0000, 32'h0, 32'hAAAA_5555}, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd3};
      vecs[7] = '{1'b1, 32'd16, {32'h0300_0003, 32'h0200_0002, 32'h0100_0001}, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd16};

      @(negedge clk);
      chk("rst_rx_ready", if0.rx_ready, 32'd0);
      chk("rst_mem_we",   if0.mem_we,   32'd0);
      chk("rst_mem_addr", if0.mem_addr, 32'd0);
      chk("rst_mem_data", if0.mem_data, 32'd0);
      chk("rst_busy",     if0.busy,     32'd0);
      chk("rst_done",     if0.done,     32'd0);
      chk("rst_error",    if0.error,    32'd0);
      chk("rst_word_cnt", if0.word_cnt, 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_vec(i, vecs[i]);
      end

      // Restart after DONE clears sticky status and reopens the byte stream.
      chk("sticky_done", if1.done, 32'd1);
      pulse_start(1'b1);
      chk("restart_done",     if1.done,     32'd0);
      chk("restart_busy",     if1.busy,     32'd1);
      chk("restart_rx_ready", if1.rx_ready, 32'd1);
      chk("restart_word_cnt", if1.word_cnt, 32'd0);
      send_word(1'b1, 32'd0, 1'b0);
      repeat (2) @(negedge clk);
      chk("restart_zero_done", if1.done, 32'd1);

      // Reset mid-session after six data bytes.
      pulse_start(1'b0);
      send_word(1'b0, 32'd3, 1'b0);
      send_word(1'b0, 32'h0102_0304, 1'b0);
      send_byte(1'b0, 8'h05, 0);
      send_byte(1'b0, 8'h06, 0);
      chk("midrst_word_cnt_pre", if0.word_cnt, 32'd1);
      rst = 1'b0;
      #1;
      chk("midrst_busy",     if0.busy,     32'd0);
      chk("midrst_rx_ready", if0.rx_ready, 32'd0);
      chk("midrst_word_cnt", if0.word_cnt, 32'd0);
      chk("midrst_mem_addr", if0.mem_addr, 32'd0);
      wa0.delete(); wd0.delete();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("midrst_nwrites", wa0.size(), 32'd0);
      chk("midrst_done",    if0.done,   32'd0);
      chk("midrst_error",   if0.error,  32'd0);
      run_vec(8, vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
